// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | run_ctrl_pkg                                                                 |
// | Shared types and constants for the core run/halt/step sequencer.             |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
package run_ctrl_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BREAK = 2'd3
  } mode_t;

  function automatic logic is_halted(input mode_t m);
    return (m == HALT) || (m == BREAK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | btn_edge                                                                     |
// | Button synchronizer followed by a one-cycle rising-edge event detector.      |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module btn_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic ev_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] flush_q;
  logic                   prev_q;
  logic                   w_armed;
  logic                   w_synced;

  assign w_synced = sync_q[SYNC_STAGES-1];
  assign w_armed  = flush_q[SYNC_STAGES-1];

  // Until the chain has refilled after reset the button is treated as already
  // pressed, so a button held through reset does not produce an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      flush_q <= '0;
      prev_q  <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
      flush_q <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= w_armed ? w_synced : 1'b1;
    end
  end

  assign ev_o = w_armed & w_synced & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/core_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_run_ctrl                                                                |
// | Run/halt/single-step sequencer producing the core clock-enable pulse.        |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module core_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int DIV_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             halt_btn,
  input  logic [DIV_W-1:0] div_val,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pcout,
  output logic             core_en,
  output logic [1:0]       mode,
  output logic             halted,
  output logic [31:0]      instr_count
);

  mode_t            mode_q, mode_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             bp_skip_q, bp_skip_d;
  logic [31:0]      icnt_q, icnt_d;

  logic w_run_ev, w_step_ev, w_halt_ev;
  logic w_tick, w_bp_hit, w_en;

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_run_edge (
    .clk   (clk),
    .rst   (rst),
    .btn_i (run_btn),
    .ev_o  (w_run_ev)
  );

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_edge (
    .clk   (clk),
    .rst   (rst),
    .btn_i (step_btn),
    .ev_o  (w_step_ev)
  );

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_halt_edge (
    .clk   (clk),
    .rst   (rst),
    .btn_i (halt_btn),
    .ev_o  (w_halt_ev)
  );

  assign w_tick   = (cnt_q >= div_val);
  assign w_bp_hit = bp_en && (pcout == bp_addr) && !bp_skip_q;

  // The enable is decoded in the same cycle as the mode register so a halt
  // event or a breakpoint on the PC the core is about to execute can veto it.
  always_comb begin
    mode_d    = mode_q;
    cnt_d     = '0;
    bp_skip_d = bp_skip_q;
    w_en      = 1'b0;
    unique case (mode_q)
      HALT: begin
        if (!w_halt_ev && w_step_ev) begin
          mode_d = STEP;
        end else if (!w_halt_ev && w_run_ev) begin
          mode_d = RUN;
        end
      end
      RUN: begin
        if (w_halt_ev) begin
          mode_d = HALT;
        end else if (w_tick) begin
          if (w_bp_hit) begin
            mode_d = BREAK;
          end else begin
            w_en      = 1'b1;
            bp_skip_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      STEP: begin
        w_en      = 1'b1;
        bp_skip_d = 1'b0;
        mode_d    = HALT;
      end
      BREAK: begin
        if (w_halt_ev) begin
          mode_d = HALT;
        end else if (w_step_ev) begin
          mode_d = STEP;
        end else if (w_run_ev) begin
          mode_d    = RUN;
          bp_skip_d = 1'b1;
        end
      end
      default: mode_d = HALT;
    endcase
  end

  assign icnt_d = w_en ? (icnt_q + 32'd1) : icnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= HALT;
      cnt_q     <= '0;
      bp_skip_q <= 1'b0;
      icnt_q    <= '0;
    end else begin
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      bp_skip_q <= bp_skip_d;
      icnt_q    <= icnt_d;
    end
  end

  assign core_en     = w_en & ~rst;
  assign mode        = mode_q;
  assign halted      = is_halted(mode_q);
  assign instr_count = icnt_q;

endmodule
`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_core_run_ctrl                                                             |
// | Directed self-checking bench with a PC scoreboard for core_run_ctrl.         |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_core_run_ctrl;
  import run_ctrl_pkg::*;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        run_btn  = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt_btn = 1'b0;
  logic [23:0] div_val  = '0;
  logic        bp_en    = 1'b0;
  logic [31:0] bp_addr  = '0;
  logic [31:0] pcout;
  logic        core_en;
  logic [1:0]  mode;
  logic        halted;
  logic [31:0] instr_count;

  logic [31:0] pc_q;
  logic [31:0] mpc;
  logic [31:0] exp_pc[$];
  int          checks = 0;
  int          errors = 0;

  core_run_ctrl #(.DIV_W(24), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .run_btn     (run_btn),
    .step_btn    (step_btn),
    .halt_btn    (halt_btn),
    .div_val     (div_val),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pcout       (pcout),
    .core_en     (core_en),
    .mode        (mode),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // Small program loop 0x00..0x1C so the PC can come back round to a breakpoint.
  function automatic logic [31:0] nextpc(input logic [31:0] pc);
    return (pc == 32'h1C) ? 32'h0 : pc + 32'd4;
  endfunction

  always @(posedge clk) begin
    if (rst) pc_q <= 32'h0;
    else if (core_en) pc_q <= nextpc(pc_q);
  end
  assign pcout = pc_q;

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic push_pcs(input int n);
    for (int i = 0; i < n; i++) begin
      exp_pc.push_back(mpc);
      mpc = nextpc(mpc);
    end
  endtask

  task automatic cyc(input string tag, input int k, input logic exp_en, input mode_t exp_mode);
    @(posedge clk);
    #1;
    chk32($sformatf("%s_en_k%0d", tag, k), {31'd0, core_en}, {31'd0, exp_en});
    chk32($sformatf("%s_mode_k%0d", tag, k), {30'd0, mode}, {30'd0, exp_mode});
    if (core_en === 1'b1) begin
      checks++;
      assert (exp_pc.size() != 0) else begin
        errors++;
        $error("FAIL %s_sb_unexpected_k%0d got pc %h exp no enable", tag, k, pcout);
      end
      if (exp_pc.size() != 0) chk32($sformatf("%s_sb_pc_k%0d", tag, k), pcout, exp_pc.pop_front());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    mpc = 32'h0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk32("rst_mode", {30'd0, mode}, {30'd0, HALT});
    chk32("rst_halted", {31'd0, halted}, 32'd1);
    chk32("rst_icnt", instr_count, 32'd0);
    chk32("rst_en", {31'd0, core_en}, 32'd0);

    // 1: held step button gives one enable, three edges after assertion
    push_pcs(1);
    step_btn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc("s1", k, k == 3, (k == 3) ? STEP : HALT);
      if (k == 5) step_btn = 1'b0;
    end
    chk32("s1_icnt", instr_count, 32'd1);
    chk32("s1_sb_left", exp_pc.size(), 32'd0);

    // 2: divide by 4, halt event lands on a tick and suppresses it
    div_val = 24'd3;
    push_pcs(9);
    @(negedge clk);
    run_btn = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      cyc("s2", k, (k >= 6) && (k < 42) && ((k - 6) % 4 == 0),
          ((k >= 3) && (k <= 42)) ? RUN : HALT);
      if (k == 5)  run_btn  = 1'b0;
      if (k == 40) halt_btn = 1'b1;
      if (k == 44) halt_btn = 1'b0;
    end
    chk32("s2_icnt", instr_count, 32'd10);
    chk32("s2_sb_left", exp_pc.size(), 32'd0);

    // 3: full rate up to a breakpoint at 0x10
    do_reset();
    chk32("s3_rst_icnt", instr_count, 32'd0);
    chk32("s3_rst_pc", pcout, 32'h0);
    div_val = 24'd0;
    bp_en   = 1'b1;
    bp_addr = 32'h10;
    push_pcs(4);
    @(negedge clk);
    run_btn = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      cyc("s3", k, (k >= 3) && (k <= 6), (k < 3) ? HALT : ((k <= 7) ? RUN : BREAK));
      if (k == 5) run_btn = 1'b0;
    end
    chk32("s3_pc", pcout, 32'h10);
    chk32("s3_halted", {31'd0, halted}, 32'd1);
    chk32("s3_icnt", instr_count, 32'd4);
    chk32("s3_sb_left", exp_pc.size(), 32'd0);

    // 4: resume executes the breakpoint instruction once, then re-breaks on loop
    push_pcs(8);
    @(negedge clk);
    run_btn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc("s4", k, (k >= 3) && (k <= 10), (k < 3) ? BREAK : ((k <= 11) ? RUN : BREAK));
      if (k == 5) run_btn = 1'b0;
    end
    chk32("s4_pc", pcout, 32'h10);
    chk32("s4_icnt", instr_count, 32'd12);
    chk32("s4_sb_left", exp_pc.size(), 32'd0);

    // 5: BREAK->HALT, then all buttons together, then run+step together
    @(negedge clk);
    halt_btn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc("s5a", k, 1'b0, (k < 3) ? BREAK : HALT);
      if (k == 3) halt_btn = 1'b0;
    end
    repeat (5) @(negedge clk);
    run_btn  = 1'b1;
    step_btn = 1'b1;
    halt_btn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc("s5b", k, 1'b0, HALT);
      if (k == 4) begin
        run_btn  = 1'b0;
        step_btn = 1'b0;
        halt_btn = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    push_pcs(1);
    run_btn  = 1'b1;
    step_btn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc("s5c", k, k == 3, (k == 3) ? STEP : HALT);
      if (k == 4) begin
        run_btn  = 1'b0;
        step_btn = 1'b0;
      end
    end
    chk32("s5_icnt", instr_count, 32'd13);
    chk32("s5_halted", {31'd0, halted}, 32'd1);
    chk32("s5_sb_left", exp_pc.size(), 32'd0);

    // 6: reset mid-RUN, button still held across reset release
    bp_en   = 1'b0;
    div_val = 24'd0;
    push_pcs(3);
    @(negedge clk);
    run_btn = 1'b1;
    for (int k = 1; k <= 5; k++) cyc("s6", k, k >= 3, (k >= 3) ? RUN : HALT);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk32("s6_rstcyc_en", {31'd0, core_en}, 32'd0);
    @(posedge clk);
    #1;
    chk32("s6_post_en", {31'd0, core_en}, 32'd0);
    chk32("s6_post_mode", {30'd0, mode}, {30'd0, HALT});
    chk32("s6_post_icnt", instr_count, 32'd0);
    chk32("s6_post_halted", {31'd0, halted}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) cyc("s6h", k, 1'b0, HALT);
    run_btn = 1'b0;
    chk32("s6_sb_left", exp_pc.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
